envelope_vca: RTL and testbench

ENVELOPE_VCA -- requirements
Module: envelope_vca

---
 rtl/envelope_vca.sv | 163 ++++++++++++++++
 tb/tb_envelope_vca.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// envelope_vca: ADSR envelope generator driving a voltage-controlled amplifier.
// The envelope advances once per prescaler tick, and gate edges take priority
// over a coincident tick. The audio sample is scaled by the envelope level,
// with one clock of latency.
module envelope_vca #(
  parameter int TICK_DIV = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gate,
  input  logic [15:0] attack_inc,
  input  logic [15:0] decay_inc,
  input  logic [15:0] sustain_lvl,
  input  logic [15:0] release_inc,
  input  logic [15:0] audio_in,
  output logic [15:0] audio_out,
  output logic [15:0] env_level,
  output logic [2:0]  state,
  output logic        active
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  logic [15:0] presc_r;
  logic        tick_s;
  logic        gate_q_r;
  logic        rise_s;
  logic        fall_s;
  state_e      state_r;
  state_e      state_nxt_s;
  logic [15:0] level_r;
  logic [15:0] level_nxt_s;
  logic        active_r;
  logic [15:0] audio_r;
  logic [16:0] atk_sum_s;
  logic [16:0] dec_diff_s;

  // Upper 16 bits of the unsigned 32-bit product sample * level.
  function automatic logic [15:0] vca_scale(input logic [15:0] sample,
                                            input logic [15:0] level);
    return 16'(({16'd0, sample} * {16'd0, level}) >> 16);
  endfunction

  assign tick_s     = (presc_r == TICK_LAST);
  assign rise_s     = gate & ~gate_q_r;
  assign fall_s     = ~gate & gate_q_r;
  assign atk_sum_s  = {1'b0, level_r} + {1'b0, attack_inc};
  assign dec_diff_s = {1'b0, level_r} - {1'b0, decay_inc};

  // Free-running prescaler: count 0..TICK_DIV-1, then wrap to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= 16'd0;
    end else if (presc_r == TICK_LAST) begin
      presc_r <= 16'd0;
    end else begin
      presc_r <= presc_r + 16'd1;
    end
  end

  // Envelope next-state and next-level decision; a gate edge suppresses the tick.
  always_comb begin
    state_nxt_s = state_r;
    level_nxt_s = level_r;
    case (state_r)
      ST_IDLE: begin
        level_nxt_s = 16'd0;
        if (rise_s) begin
          state_nxt_s = ST_ATTACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ATTACK: begin
        if (fall_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (tick_s) begin
          if (atk_sum_s >= 17'h0FFFF) begin
            level_nxt_s = 16'hFFFF;
            state_nxt_s = ST_DECAY;
          end else begin
            level_nxt_s = atk_sum_s[15:0];
          end
        end else begin
          level_nxt_s = level_r;
        end
      end
      ST_DECAY: begin
        if (fall_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (tick_s) begin
          // Underflow (bit 16 set) also counts as reaching sustain.
          if (dec_diff_s[16] || (dec_diff_s[15:0] <= sustain_lvl)) begin
            level_nxt_s = sustain_lvl;
            state_nxt_s = ST_SUSTAIN;
          end else begin
            level_nxt_s = dec_diff_s[15:0];
          end
        end else begin
          level_nxt_s = level_r;
        end
      end
      ST_SUSTAIN: begin
        if (fall_s) begin
          state_nxt_s = ST_RELEASE;
        end else if (tick_s) begin
          level_nxt_s = sustain_lvl;
        end else begin
          level_nxt_s = level_r;
        end
      end
      ST_RELEASE: begin
        if (rise_s) begin
          state_nxt_s = ST_ATTACK;
        end else if (tick_s) begin
          if (release_inc >= level_r) begin
            level_nxt_s = 16'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            level_nxt_s = level_r - release_inc;
          end
        end else begin
          level_nxt_s = level_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        level_nxt_s = 16'd0;
      end
    endcase
  end

  // State, level, activity flag, gate history and scaled audio registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q_r <= 1'b0;
      state_r  <= ST_IDLE;
      level_r  <= 16'd0;
      active_r <= 1'b0;
      audio_r  <= 16'd0;
    end else begin
      gate_q_r <= gate;
      state_r  <= state_nxt_s;
      level_r  <= level_nxt_s;
      active_r <= (state_nxt_s != ST_IDLE);
      audio_r  <= vca_scale(audio_in, level_r);
    end
  end

  assign env_level = level_r;
  assign state     = state_r;
  assign active    = active_r;
  assign audio_out = audio_r;

endmodule

// File: tb/tb_envelope_vca.sv
// Testbench for envelope_vca with TICK_DIV = 4: a table of directed checkpoints
// plus hand-written reset and saturation sequences.
module tb_envelope_vca;

  logic        clk;
  logic        rst_n;
  logic        gate;
  logic [15:0] attack_inc;
  logic [15:0] decay_inc;
  logic [15:0] sustain_lvl;
  logic [15:0] release_inc;
  logic [15:0] audio_in;
  logic [15:0] audio_out;
  logic [15:0] env_level;
  logic [2:0]  state;
  logic        active;

  int tests_run;
  int tests_failed;
  int ecount;

  typedef struct {
    int          edge_no;     // absolute edge count after reset release
    logic [2:0]  exp_state;
    logic [15:0] exp_level;
    logic        chk_audio;
    logic [15:0] exp_audio;
    logic        gate_next;   // driven after the check
    logic [15:0] sus_next;    // driven after the check
  } vec_t;

  vec_t vecs[$];

  envelope_vca #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack_inc(attack_inc), .decay_inc(decay_inc),
    .sustain_lvl(sustain_lvl), .release_inc(release_inc),
    .audio_in(audio_in), .audio_out(audio_out),
    .env_level(env_level), .state(state), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter local to the bench; edge 1 is the first posedge after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance to just after the given edge, bounded.
  task automatic goto_edge(input int target);
    int guard;
    guard = 0;
    while (ecount < target && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (ecount != target) begin
      tests_run++;
      tests_failed++;
      $display("FAIL goto_edge: got edge %0d expected %0d", ecount, target);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",  {29'd0, state}, 32'd0);
    check("reset_level",  {16'd0, env_level}, 32'd0);
    check("reset_active", {31'd0, active}, 32'd0);
    check("reset_audio",  {16'd0, audio_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input int e, input logic [2:0] st, input logic [15:0] lv,
                     input logic ca, input logic [15:0] au,
                     input logic g, input logic [15:0] s);
    vec_t v;
    v.edge_no = e; v.exp_state = st; v.exp_level = lv;
    v.chk_audio = ca; v.exp_audio = au; v.gate_next = g; v.sus_next = s;
    vecs.push_back(v);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    gate         = 1'b0;
    attack_inc   = 16'h4000;
    decay_inc    = 16'h3000;
    sustain_lvl  = 16'h8000;
    release_inc  = 16'h2500;
    audio_in     = 16'hFFFF;

    //   edge st    level     audio?  audio     gate  sustain
    add( 1, 3'd1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h8000); // gate high at reset release
    add( 3, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8000); // no tick yet
    add( 4, 3'd1, 16'h4000, 1'b1, 16'h0000, 1'b1, 16'h8000);
    add( 5, 3'd1, 16'h4000, 1'b1, 16'h3FFF, 1'b1, 16'h8000);
    add( 8, 3'd1, 16'h8000, 1'b0, 16'h0000, 1'b1, 16'h8000);
    add(12, 3'd1, 16'hC000, 1'b0, 16'h0000, 1'b1, 16'h8000);
    add(15, 3'd1, 16'hC000, 1'b1, 16'hBFFF, 1'b1, 16'h8000);
    add(16, 3'd2, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h8000); // saturate -> DECAY
    add(17, 3'd2, 16'hFFFF, 1'b1, 16'hFFFE, 1'b1, 16'h8000);
    add(20, 3'd2, 16'hCFFF, 1'b0, 16'h0000, 1'b1, 16'h8000);
    add(24, 3'd2, 16'h9FFF, 1'b0, 16'h0000, 1'b1, 16'h8000);
    add(28, 3'd3, 16'h8000, 1'b1, 16'h9FFE, 1'b1, 16'h6000); // SUSTAIN, audio lags level
    add(29, 3'd3, 16'h8000, 1'b1, 16'h7FFF, 1'b1, 16'h6000);
    add(32, 3'd3, 16'h6000, 1'b0, 16'h0000, 1'b1, 16'h6000); // tracks new sustain
    add(35, 3'd3, 16'h6000, 1'b0, 16'h0000, 1'b0, 16'h6000); // fall lands on tick edge 36
    add(36, 3'd4, 16'h6000, 1'b1, 16'h5FFF, 1'b0, 16'h6000); // RELEASE, level unchanged
    add(40, 3'd4, 16'h3B00, 1'b0, 16'h0000, 1'b1, 16'h6000); // retrigger
    add(41, 3'd1, 16'h3B00, 1'b0, 16'h0000, 1'b1, 16'h6000);
    add(44, 3'd1, 16'h7B00, 1'b0, 16'h0000, 1'b0, 16'h6000);
    add(45, 3'd4, 16'h7B00, 1'b0, 16'h0000, 1'b0, 16'h6000);
    add(48, 3'd4, 16'h5600, 1'b0, 16'h0000, 1'b0, 16'h6000);
    add(52, 3'd4, 16'h3100, 1'b0, 16'h0000, 1'b0, 16'h6000);
    add(56, 3'd4, 16'h0C00, 1'b0, 16'h0000, 1'b0, 16'h6000);
    add(60, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h6000); // IDLE
    add(61, 3'd0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h6000);
    add(64, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h6000);

    gate = 1'b1;
    do_reset();
    foreach (vecs[i]) begin
      goto_edge(vecs[i].edge_no);
      check($sformatf("state@%0d", vecs[i].edge_no), {29'd0, state}, {29'd0, vecs[i].exp_state});
      check($sformatf("level@%0d", vecs[i].edge_no), {16'd0, env_level}, {16'd0, vecs[i].exp_level});
      check($sformatf("active@%0d", vecs[i].edge_no), {31'd0, active},
            {31'd0, (vecs[i].exp_state != 3'd0)});
      if (vecs[i].chk_audio)
        check($sformatf("audio@%0d", vecs[i].edge_no), {16'd0, audio_out}, {16'd0, vecs[i].exp_audio});
      gate        = vecs[i].gate_next;
      sustain_lvl = vecs[i].sus_next;
    end

    // Reset mid-ATTACK clears outputs without a clock edge.
    attack_inc  = 16'h4000;
    sustain_lvl = 16'h8000;
    gate        = 1'b1;
    do_reset();
    goto_edge(6);
    check("midatk_level", {16'd0, env_level}, 32'h0000_4000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state",  {29'd0, state}, 32'd0);
    check("async_level",  {16'd0, env_level}, 32'd0);
    check("async_active", {31'd0, active}, 32'd0);
    check("async_audio",  {16'd0, audio_out}, 32'd0);

    // Full-scale attack, decay entered at sustain, zero-increment release stall.
    attack_inc  = 16'hFFFF;
    decay_inc   = 16'h0000;
    sustain_lvl = 16'hFFFF;
    release_inc = 16'h0000;
    gate        = 1'b1;
    do_reset();
    goto_edge(4);
    check("sat_state", {29'd0, state}, 32'd2);
    check("sat_level", {16'd0, env_level}, 32'h0000_FFFF);
    goto_edge(8);
    check("dec_at_sus_state", {29'd0, state}, 32'd3);
    gate = 1'b0;
    goto_edge(16);
    check("rel_stall_state", {29'd0, state}, 32'd4);
    check("rel_stall_level", {16'd0, env_level}, 32'h0000_FFFF);
    release_inc = 16'hFFFF;
    goto_edge(20);
    check("rel_full_state", {29'd0, state}, 32'd0);
    check("rel_full_level", {16'd0, env_level}, 32'd0);
    check("rel_full_active", {31'd0, active}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
